// File: rtl/uart_tx_arb.sv
// Round-robin arbiter/sequencer sharing one uart_tx between NUM_REQ byte producers.
// Optional feature macro: UART_TX_ARB_LOCK_EN (adds req_lock for contiguous multi-byte messages).
module uart_tx_arb #(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = 16,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
`ifdef UART_TX_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]   req_lock,
`endif
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_send,
    input  logic                 tx_ready,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy,
    output logic                 err_timeout
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        BUSY
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_send_q, tx_send_d;
    logic [IDW-1:0]  grant_id_q, grant_id_d;
    logic            err_timeout_q, err_timeout_d;
`ifdef UART_TX_ARB_LOCK_EN
    logic            owner_q, owner_d;
    logic            lock_hold;
`endif

    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  cand;
    int              cand_sum;
    logic            found;
    logic            grant;

    // Search starts just after the last winner, so rr_ptr=NUM_REQ-1 wraps to requester 0.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        cand_sum = 0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_sum = int'(rr_ptr_q) + k;
            if (cand_sum >= NUM_REQ) begin
                cand_sum = cand_sum - NUM_REQ;
            end
            cand = IDW'(cand_sum);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
`ifdef UART_TX_ARB_LOCK_EN
        lock_hold = owner_q && req_lock[grant_id_q] && req_valid[grant_id_q];
        if (lock_hold) begin
            found  = 1'b1;
            winner = grant_id_q;
        end
`endif
    end

    assign grant     = (state_q == IDLE) && !rst && tx_ready && found;
    assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        cnt_d         = cnt_q;
        tx_data_d     = tx_data_q;
        tx_send_d     = tx_send_q;
        grant_id_d    = grant_id_q;
        err_timeout_d = 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
        owner_d       = owner_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef UART_TX_ARB_LOCK_EN
                if (!lock_hold) begin
                    owner_d = 1'b0;
                end
`endif
                if (grant) begin
                    tx_data_d  = req_data[{winner, 3'b000} +: 8];
                    grant_id_d = winner;
                    rr_ptr_d   = winner;
                    tx_send_d  = 1'b1;
                    cnt_d      = '0;
                    state_d    = SEND;
`ifdef UART_TX_ARB_LOCK_EN
                    owner_d    = 1'b1;
`endif
                end
            end
            SEND: begin
                if (!tx_ready) begin
                    tx_send_d = 1'b0;
                    state_d   = BUSY;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    // Transmitter never acknowledged: drop the byte rather than retry.
                    tx_send_d     = 1'b0;
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            BUSY: begin
                if (tx_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                tx_send_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= IDW'(NUM_REQ - 1);
            cnt_q         <= '0;
            tx_data_q     <= 8'h00;
            tx_send_q     <= 1'b0;
            grant_id_q    <= '0;
            err_timeout_q <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
            owner_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            cnt_q         <= cnt_d;
            tx_data_q     <= tx_data_d;
            tx_send_q     <= tx_send_d;
            grant_id_q    <= grant_id_d;
            err_timeout_q <= err_timeout_d;
`ifdef UART_TX_ARB_LOCK_EN
            owner_q       <= owner_d;
`endif
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_send     = tx_send_q;
    assign grant_id    = grant_id_q;
    assign err_timeout = err_timeout_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: random producers, behavioural uart_tx model and
// a round-robin reference model; frames and timeouts are checked by a separate monitor.
module tb_uart_tx_arb;

    localparam int N    = 4;
    localparam int TO   = 16;
    localparam int BITC = 4;
    localparam int IDW  = $clog2(N);
    localparam int DEPTH = 128;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_send;
    logic           tx_ready = 1'b1;
    logic [IDW-1:0] grant_id;
    logic           busy;
    logic           err_timeout;
`ifdef UART_TX_ARB_LOCK_EN
    logic [N-1:0]   req_lock = '0;
`endif

    uart_tx_arb #(.NUM_REQ(N), .ACK_TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
`ifdef UART_TX_ARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .tx_send    (tx_send),
        .tx_ready   (tx_ready),
        .grant_id   (grant_id),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] data;
        bit         drop;
        bit         nocheck;
    } exp_t;

    typedef struct {
        logic [9:0]     bits;
        logic [IDW-1:0] gid;
    } frame_t;

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [7:0] mem [N][DEPTH];
    int         head [N];
    int         tail [N];
    bit         pop_req [N];
    bit         valid_rand = 1'b0;
    bit         stub = 1'b0;
    exp_t       exp_q[$];
    frame_t     rx_q[$];
    logic [7:0] log_q[$];
    logic [9:0] last_bits = '0;
    int         err_cnt = 0;
    bit         tx_busy = 1'b0;
    int         tx_bit = 0;
    int         rr_m = N - 1;
    int         wait_ph = 0;
    int         stub_left = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name);
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL %s: event with no pending expectation", name);
    endtask

    task automatic applyStimulus(input int id, input logic [7:0] data);
        mem[id][tail[id]] = data;
        tail[id]++;
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    function automatic bit producersEmpty();
        for (int i = 0; i < N; i++) begin
            if (head[i] != tail[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Producers: present the head byte of each queue, optionally with random gaps.
    initial begin : driver
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            pop_req[i] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (pop_req[i]) begin
                    head[i]++;
                    pop_req[i] = 1'b0;
                end
                if (head[i] < tail[i]) begin
                    req_data[8*i +: 8] = mem[i][head[i]];
                    req_valid[i] = valid_rand ? ($urandom_range(3) != 0) : 1'b1;
                end else begin
                    req_data[8*i +: 8] = 8'($urandom);
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Behavioural transmitter: samples tx_data bit-by-bit, or ignores send entirely when stubbed.
    initial begin : tx_model
        int     tx_cyc;
        frame_t f;
        logic [2:0] bi;
        tx_cyc = 0;
        f.bits = '0;
        f.gid = '0;
        forever begin
            @(posedge clk);
            #1;
            if (stub) begin
                tx_ready = 1'b1;
                tx_busy = 1'b0;
            end else if (!tx_busy) begin
                if (tx_send === 1'b1) begin
                    tx_busy = 1'b1;
                    tx_ready = 1'b0;
                    tx_bit = 0;
                    tx_cyc = 0;
                    f.bits = '0;
                    f.gid = grant_id;
                end
            end else begin
                tx_cyc++;
                if (tx_cyc == BITC) begin
                    tx_cyc = 0;
                    tx_bit++;
                    if (tx_bit == 10) begin
                        tx_busy = 1'b0;
                        tx_ready = 1'b1;
                        rx_q.push_back(f);
                    end else if (tx_bit <= 8) begin
                        bi = 3'(tx_bit - 1);
                        f.bits[tx_bit] = tx_data[bi];
                    end else begin
                        f.bits[9] = 1'b1;
                    end
                end
            end
        end
    end

    // Reference arbiter: decides when a grant must appear and which requester wins.
    initial begin : ref_checker
        int   w;
        bit   blocked;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                checkOutput("ready_in_reset", 32'(req_ready), 32'd0);
                rr_m = N - 1;
                wait_ph = 0;
                stub_left = 0;
            end else begin
                blocked = (wait_ph != 0) || (stub_left != 0) || (tx_ready !== 1'b1);
                if (!blocked && (req_valid != '0)) begin
                    w = pick(req_valid, rr_m);
                    checkOutput("grant_onehot", 32'(req_ready), 32'd1 << w);
                    e.id = w;
                    e.data = mem[w][head[w]];
                    e.drop = stub;
                    e.nocheck = 1'b0;
                    exp_q.push_back(e);
                    pop_req[w] = 1'b1;
                    rr_m = w;
                    if (stub) stub_left = TO;
                    else wait_ph = 1;
                end else begin
                    checkOutput("no_grant", 32'(req_ready), 32'd0);
                    if (stub_left > 0) stub_left--;
                    if (wait_ph == 1 && tx_ready === 1'b0) wait_ph = 2;
                    else if (wait_ph == 2 && tx_ready === 1'b1) wait_ph = 0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard for every finished frame and every timeout pulse.
    initial begin : monitor
        frame_t f;
        exp_t   e;
        int     send_len;
        send_len = 0;
        forever begin
            @(negedge clk);
            if (rx_q.size() > 0) begin
                f = rx_q.pop_front();
                last_bits = f.bits;
                log_q.push_back(f.bits[8:1]);
                if (exp_q.size() == 0) begin
                    reportFail("frame_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("frame_not_dropped", 32'(e.drop), 32'd0);
                    if (!e.nocheck) begin
                        checkOutput("frame_data", 32'(f.bits[8:1]), 32'(e.data));
                        checkOutput("frame_grant_id", 32'(f.gid), 32'(e.id));
                    end
                end
            end
            if (err_timeout === 1'b1) begin
                err_cnt++;
                if (exp_q.size() == 0) begin
                    reportFail("timeout_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("timeout_expected", 32'(e.drop), 32'd1);
                end
            end
            if (tx_send === 1'b1) begin
                send_len++;
            end else if (send_len > 0) begin
                checkOutput("send_width", 32'(send_len), stub ? 32'(TO) : 32'd1);
                send_len = 0;
            end
        end
    end

    task automatic waitDrain(input string name, input int budget);
        int cyc;
        bit done;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            done = producersEmpty() && (exp_q.size() == 0) && (wait_ph == 0) &&
                   (stub_left == 0) && !tx_busy;
        end
        checkOutput({name, "_drained"}, 32'(done), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_tx_data", 32'(tx_data), 32'h00);
        checkOutput("rst_tx_send", 32'(tx_send), 32'd0);
        checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
        checkOutput("rst_err", 32'(err_timeout), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int c;
        int id;
        doReset();

        // Single byte from requester 0.
        applyStimulus(0, 8'hA5);
        waitDrain("single", 500);
        checkOutput("single_serial", 32'(last_bits), 32'(10'b1101001010));
        checkOutput("single_grant_id", 32'(grant_id), 32'd0);
        checkOutput("single_data_held", 32'(tx_data), 32'hA5);

        // Fairness from reset: all four continuously valid.
        doReset();
        log_q.delete();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) applyStimulus(i, 8'(8'h10 + i));
        end
        waitDrain("fair", 2000);
        checkOutput("fair_count", 32'(log_q.size()), 32'd12);
        for (int k = 0; k < 12 && k < log_q.size(); k++) begin
            checkOutput("fair_order", 32'(log_q[k]), 32'(8'h10 + (k % N)));
        end

        // Timeout: transmitter never drops tx_ready.
        stub = 1'b1;
        err_cnt = 0;
        applyStimulus(1, 8'h77);
        applyStimulus(2, 8'h88);
        waitDrain("timeout", 500);
        checkOutput("timeout_pulses", 32'(err_cnt), 32'd2);
        checkOutput("timeout_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        stub = 1'b0;
        applyStimulus(3, 8'h3C);
        applyStimulus(0, 8'h0F);
        waitDrain("after_timeout", 500);

        // Reset in the middle of a frame, then backpressure while the line finishes.
        applyStimulus(3, 8'h5C);
        c = 0;
        while (!(tx_busy && tx_bit == 4) && c < 500) begin
            @(negedge clk);
            c++;
        end
        checkOutput("midreset_reached", 32'(c < 500), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        if (exp_q.size() > 0) exp_q[exp_q.size() - 1].nocheck = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1, 8'hC3);
        @(negedge clk);
        checkOutput("midreset_send", 32'(tx_send), 32'd0);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        waitDrain("midreset", 1000);

        // Randomised traffic with random valid gaps.
        valid_rand = 1'b1;
        for (int k = 0; k < 60; k++) begin
            id = $urandom_range(N - 1);
            applyStimulus(id, 8'($urandom));
        end
        waitDrain("random", 8000);
        valid_rand = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
